fetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit microRISC core, directly upstream of instruction_memory.
- Owns the program counter and drives the memory's 9-bit byte address.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential fetch, branch/jump redirects, stalls, pipeline flushes and halt.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 14 +
 rtl/fetch_unit_if_id_reg.sv | 37 +++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the microRISC fetch stage: datapath widths, the NOP
// encoding, FSM state encodings and a PC alignment helper.
package fetch_unit_pkg;

   localparam int PC_W   = 9;
   localparam int INST_W = 16;

   localparam logic [INST_W-1:0] NOP_ENC = 16'h0000;

   typedef logic [1:0] state_t;

   localparam state_t ST_BOOT   = 2'd0;
   localparam state_t ST_RUN    = 2'd1;
   localparam state_t ST_HALTED = 2'd2;

   // Clear bit 0 so the address lands on a 16-bit instruction boundary.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:1], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction_memory.
// There is no handshake on this bus: the fetch stage presents imem_addr
// combinationally every cycle and the memory returns imem_inst in the same
// cycle, so the word is always valid at the next rising edge.
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_inst;

   modport master (output imem_addr, input imem_inst);
   modport slave  (input imem_addr, output imem_inst);

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. flush inserts a bubble (NOP, invalid) and records
// fetch_pc; hold keeps the current contents; otherwise the fetched word is
// captured as a valid instruction. flush wins over hold.
module fetch_unit_if_id_reg
   import fetch_unit_pkg::*;
#(
   parameter logic [INST_W-1:0] NOP_INST = NOP_ENC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              flush,
   input  logic [INST_W-1:0] fetch_inst,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic [INST_W-1:0] inst,
   output logic [PC_W-1:0]   inst_pc,
   output logic              valid
);

   // Bubble on flush, capture on advance, otherwise keep the stage contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inst    <= NOP_INST;
         inst_pc <= '0;
         valid   <= 1'b0;
      end else if (flush) begin
         inst    <= NOP_INST;
         inst_pc <= fetch_pc;
         valid   <= 1'b0;
      end else if (!hold) begin
         inst    <= fetch_inst;
         inst_pc <= fetch_pc;
         valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the microRISC core: owns the PC, the next-PC mux
// and the BOOT/RUN/HALTED FSM, and feeds the IF/ID register.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (odd redirect target traps
// into HALTED with a sticky misalign_fault instead of being word-aligned).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC = 9'h000,
   parameter logic [INST_W-1:0] NOP_INST = NOP_ENC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt_req,
   fetch_unit_if.master      bus,
   output logic [INST_W-1:0] if_id_inst,
   output logic [PC_W-1:0]   if_id_pc,
   output logic              if_id_valid,
   output logic [PC_W-1:0]   pc,
   output logic              halted,
   output logic              misalign_fault,
   output state_t            fsm_state
);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_t          state;
   state_t          state_next;
   logic [PC_W-1:0] pc_next;
   logic            ifid_hold;
   logic            ifid_flush;
   logic            misalign_hit;

   // An odd target only matters when the trap is built in; otherwise it is aligned.
   assign misalign_hit = TRAP_EN && redirect_pc[0];

   // State register: reset always lands in BOOT.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_BOOT;
      else        state <= state_next;
   end

   // Next state: BOOT is a single idle cycle; HALTED is left only by reset.
   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT:   state_next = ST_RUN;
         ST_RUN: begin
            if (redirect) begin
               if (misalign_hit) state_next = ST_HALTED;
            end else if (halt_req) begin
               state_next = ST_HALTED;
            end
         end
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_BOOT;
      endcase
   end

   // Datapath controls: in RUN, redirect > halt > stall > sequential fetch.
   always_comb begin
      pc_next    = pc;
      ifid_hold  = 1'b1;
      ifid_flush = 1'b0;
      if (state == ST_RUN) begin
         if (redirect) begin
            ifid_flush = 1'b1;
            if (!misalign_hit) pc_next = align_pc(redirect_pc);
         end else if (halt_req) begin
            ifid_flush = 1'b1;
         end else if (!stall) begin
            ifid_hold = 1'b0;
            pc_next   = pc + 9'd2;
         end
      end
   end

   // Program counter; the 9-bit add wraps 1FE back to 000.
   always_ff @(posedge clk) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= pc_next;
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n)                                            misalign_fault <= 1'b0;
      else if ((state == ST_RUN) && redirect && misalign_hit) misalign_fault <= 1'b1;
   end
`else
   assign misalign_fault = 1'b0;
`endif

   fetch_unit_if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .hold       (ifid_hold),
      .flush      (ifid_flush),
      .fetch_inst (bus.imem_inst),
      .fetch_pc   (pc),
      .inst       (if_id_inst),
      .inst_pc    (if_id_pc),
      .valid      (if_id_valid)
   );

   assign bus.imem_addr = pc;
   assign halted        = (state == ST_HALTED);
   assign fsm_state     = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle halt/reset
// sequences, then randomized traffic against a behavioural fetch model.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [8:0]  redirect_pc = '0;
   logic        halt_req = 1'b0;
   logic [15:0] if_id_inst;
   logic [8:0]  if_id_pc;
   logic        if_id_valid;
   logic [8:0]  pc;
   logic        halted;
   logic        misalign_fault;
   state_t      fsm_state;

   logic [15:0] mem [256];

   int checks = 0;
   int failures = 0;

   // behavioural model state
   logic [8:0]  m_pc;
   logic [15:0] m_inst;
   logic [8:0]  m_ipc;
   logic        m_valid;
   logic        m_halted;
   logic        m_booting;
   logic        m_fault;

   typedef struct {
      logic        st;
      logic        rd;
      logic [8:0]  rpc;
      logic        hq;
      logic [8:0]  e_pc;
      logic [15:0] e_inst;
      logic [8:0]  e_ipc;
      logic        e_valid;
      logic        e_halted;
      logic        e_fault;
   } vec_t;

   vec_t vecs[14];

   fetch_unit_if bus();

   // instruction memory: combinational word read
   assign bus.imem_inst = mem[bus.imem_addr[8:1]];

   // clock generation
   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .halt_req       (halt_req),
      .bus            (bus),
      .if_id_inst     (if_id_inst),
      .if_id_pc       (if_id_pc),
      .if_id_valid    (if_id_valid),
      .pc             (pc),
      .halted         (halted),
      .misalign_fault (misalign_fault),
      .fsm_state      (fsm_state)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic rd, input logic [8:0] rpc, input logic hq,
                               input logic [8:0] e_pc, input logic [15:0] e_inst, input logic [8:0] e_ipc,
                               input logic e_valid, input logic e_halted, input logic e_fault);
      vec_t v;
      v.st = st; v.rd = rd; v.rpc = rpc; v.hq = hq;
      v.e_pc = e_pc; v.e_inst = e_inst; v.e_ipc = e_ipc;
      v.e_valid = e_valid; v.e_halted = e_halted; v.e_fault = e_fault;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic rd, input logic [8:0] rpc, input logic hq);
      stall = st; redirect = rd; redirect_pc = rpc; halt_req = hq;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 9'h000, 1'b0);
      repeat (2) tick();
   endtask

   task automatic check_outputs(input string tag, input logic [8:0] e_pc, input logic [15:0] e_inst,
                                input logic [8:0] e_ipc, input logic e_valid, input logic e_halted,
                                input logic e_fault);
      chk({tag, ".pc"}, 16'(pc), 16'(e_pc));
      chk({tag, ".imem_addr"}, 16'(bus.imem_addr), 16'(e_pc));
      chk({tag, ".if_id_inst"}, if_id_inst, e_inst);
      chk({tag, ".if_id_pc"}, 16'(if_id_pc), 16'(e_ipc));
      chk({tag, ".if_id_valid"}, 16'(if_id_valid), 16'(e_valid));
      chk({tag, ".halted"}, 16'(halted), 16'(e_halted));
      chk({tag, ".misalign_fault"}, 16'(misalign_fault), 16'(e_fault));
   endtask

   // One rising edge of the fetch stage as described by its rules.
   task automatic model_edge(input logic r_n, input logic st, input logic rd,
                             input logic [8:0] rpc, input logic hq);
      logic [15:0] word;
      word = mem[m_pc[8:1]];
      if (!r_n) begin
         m_pc = 9'h000; m_inst = 16'h0000; m_ipc = 9'h000;
         m_valid = 1'b0; m_halted = 1'b0; m_booting = 1'b1; m_fault = 1'b0;
      end else if (m_booting) begin
         m_booting = 1'b0;
      end else if (m_halted) begin
         // frozen until reset
      end else if (rd) begin
         m_inst = 16'h0000; m_valid = 1'b0; m_ipc = m_pc;
         if (TRAP && rpc[0]) begin
            m_fault = 1'b1; m_halted = 1'b1;
         end else begin
            m_pc = 9'(int'(rpc) / 2 * 2);
         end
      end else if (hq) begin
         m_inst = 16'h0000; m_valid = 1'b0; m_ipc = m_pc; m_halted = 1'b1;
      end else if (!st) begin
         m_inst = word; m_ipc = m_pc; m_valid = 1'b1;
         m_pc = 9'((int'(m_pc) + 2) % 512);
      end
   endtask

   initial begin
      int halt_cnt;
      logic [8:0] frozen_pc;

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;
      mem[255] = 16'hC0DE;

      vecs[0]  = mk(0, 0, 9'h000, 0, 9'h000, 16'h0000, 9'h000, 0, 0, 0);
      vecs[1]  = mk(0, 0, 9'h000, 0, 9'h002, 16'h1234, 9'h000, 1, 0, 0);
      vecs[2]  = mk(0, 0, 9'h000, 0, 9'h004, 16'h5678, 9'h002, 1, 0, 0);
      vecs[3]  = mk(1, 0, 9'h000, 0, 9'h004, 16'h5678, 9'h002, 1, 0, 0);
      vecs[4]  = mk(1, 0, 9'h000, 0, 9'h004, 16'h5678, 9'h002, 1, 0, 0);
      vecs[5]  = mk(1, 0, 9'h000, 0, 9'h004, 16'h5678, 9'h002, 1, 0, 0);
      vecs[6]  = mk(0, 0, 9'h000, 0, 9'h006, 16'h9ABC, 9'h004, 1, 0, 0);
      vecs[7]  = mk(1, 1, 9'h002, 0, 9'h002, 16'h0000, 9'h006, 0, 0, 0);
      vecs[8]  = mk(0, 0, 9'h000, 0, 9'h004, 16'h5678, 9'h002, 1, 0, 0);
      vecs[9]  = mk(0, 1, 9'h1FE, 0, 9'h1FE, 16'h0000, 9'h004, 0, 0, 0);
      vecs[10] = mk(0, 0, 9'h000, 0, 9'h000, 16'hC0DE, 9'h1FE, 1, 0, 0);
      vecs[11] = mk(0, 0, 9'h000, 0, 9'h002, 16'h1234, 9'h000, 1, 0, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
      vecs[12] = mk(0, 1, 9'h005, 0, 9'h002, 16'h0000, 9'h002, 0, 1, 1);
      vecs[13] = mk(0, 0, 9'h000, 0, 9'h002, 16'h0000, 9'h002, 0, 1, 1);
`else
      vecs[12] = mk(0, 1, 9'h005, 0, 9'h004, 16'h0000, 9'h002, 0, 0, 0);
      vecs[13] = mk(0, 0, 9'h000, 0, 9'h006, 16'h9ABC, 9'h004, 1, 0, 0);
`endif

      // reset state
      do_reset();
      check_outputs("reset", 9'h000, 16'h0000, 9'h000, 0, 0, 0);
      chk("reset.fsm_state", 16'(fsm_state), 16'(ST_BOOT));
      rst_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].hq);
         tick();
         check_outputs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_ipc,
                       vecs[i].e_valid, vecs[i].e_halted, vecs[i].e_fault);
      end

      // halt with stall asserted, then held frozen for 10 cycles
      do_reset();
      rst_n = 1'b1;
      repeat (3) tick();
      chk("pre_halt.fsm_state", 16'(fsm_state), 16'(ST_RUN));
      drive(1'b1, 1'b0, 9'h000, 1'b1);
      tick();
      chk("halt.halted", 16'(halted), 16'h1);
      chk("halt.valid", 16'(if_id_valid), 16'h0);
      chk("halt.pc", 16'(pc), 16'h004);
      for (int i = 0; i < 10; i++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               9'($urandom_range(0, 255) * 2), 1'b0);
         tick();
         chk($sformatf("halted%0d.halted", i), 16'(halted), 16'h1);
         chk($sformatf("halted%0d.valid", i), 16'(if_id_valid), 16'h0);
         chk($sformatf("halted%0d.pc", i), 16'(pc), 16'h004);
      end
      rst_n = 1'b0;
      tick();
      chk("halt_reset.pc", 16'(pc), 16'h000);
      chk("halt_reset.halted", 16'(halted), 16'h0);

      // reset wins over a simultaneous redirect, stall and halt request
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 9'h000, 1'b0);
      repeat (4) tick();
      frozen_pc = pc;
      chk("pre_rst.pc", 16'(frozen_pc), 16'h006);
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 9'h0A0, 1'b1);
      tick();
      chk("rst_over.pc", 16'(pc), 16'h000);
      chk("rst_over.valid", 16'(if_id_valid), 16'h0);
      chk("rst_over.halted", 16'(halted), 16'h0);
      chk("rst_over.inst", if_id_inst, 16'h0000);

      // randomized traffic against the model
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      model_edge(1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
      halt_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) != 0);
         if (m_halted) halt_cnt++;
         else          halt_cnt = 0;
         if (halt_cnt > 15) rst_n = 1'b0;
         drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
               9'($urandom_range(0, 511)), ($urandom_range(0, 59) == 0));
         model_edge(rst_n, stall, redirect, redirect_pc, halt_req);
         tick();
         check_outputs("rnd", m_pc, m_inst, m_ipc, m_valid, m_halted, m_fault);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
